lsu_bus_ctrl: RTL and testbench

- Load/store unit that sits directly downstream of the core's ALU/control path and replaces the zero-latency data memory with a multi-cycle, handshaked data bus.
- Takes the core's load/store request (address = ALU result, store data = rs2, funct3) and generates byte-lane strobes, aligned bus address and replicated write data.
- Stalls the core until the bus completes, then returns a sign- or zero-extended load result for write-back.
- Includes a bus timeout watchdog.

---
 rtl/lsu_pkg.sv | 33 +++
 rtl/lsu_align.sv | 59 +++++
 rtl/lsu_bus_ctrl.sv | 173 +++++++++++++++++
 tb/tb_lsu_bus_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store bus controller.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} lsu_state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_txn_t;

  // Anything other than the five legal load/store encodings is reserved.
  function automatic logic f3_reserved(input logic [2:0] f3);
    return !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  endfunction

  // Byte offset actually used for an access: misaligned low bits are dropped.
  function automatic logic [1:0] eff_offset(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (f3[1:0])
      2'b00:   return addr_lo;
      2'b01:   return {addr_lo[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: strobes and replicated store data for the request side,
// lane extraction and sign/zero extension for the load response side.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic        bad_f3,
  output logic        misalign,
  input  logic [2:0]  rsp_funct3,
  input  logic [1:0]  rsp_addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] rdata_ext
);

  logic [1:0]  rsp_off;
  logic [31:0] shifted;

  // Request side: strobes, store data replication and fault classification.
  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata;
    case (funct3[1:0])
      2'b00: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      2'b01: begin
        be        = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
      end
      default: begin
        be        = 4'b1111;
        wdata_rep = wdata;
      end
    endcase
    bad_f3   = f3_reserved(funct3);
    misalign = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
               ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
  end

  // Response side: shift the addressed lane down, then extend.
  always_comb begin
    rsp_off   = eff_offset(rsp_funct3, rsp_addr_lo);
    shifted   = rdata >> {rsp_off, 3'b000};
    rdata_ext = shifted;
    case (rsp_funct3)
      F3_B:    rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   rdata_ext = {24'd0, shifted[7:0]};
      F3_H:    rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   rdata_ext = {16'd0, shifted[15:0]};
      default: rdata_ext = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// Load/store unit bridging the core's single-cycle memory interface to a
// handshaked data bus, with a timeout watchdog over the REQ/WAIT phases.
// Build option: define LSU_MISALIGN_EXC_EN to fault misaligned H/W accesses
// instead of truncating the low address bits.
module lsu_bus_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        lsu_stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

`ifdef LSU_MISALIGN_EXC_EN
  localparam bit MisalignExc = 1'b1;
`else
  localparam bit MisalignExc = 1'b0;
`endif

  lsu_state_t       state_q;
  bus_txn_t         txn_q;
  logic [2:0]       f3_q;
  logic [1:0]       alo_q;
  logic [CNT_W-1:0] cnt_q;
  logic             bus_req_q;
  logic             rsp_valid_q;
  logic [31:0]      rsp_rdata_q;
  logic             rsp_err_q;

  logic [3:0]  align_be;
  logic [31:0] align_wdata;
  logic        bad_f3;
  logic        misalign;
  logic [31:0] rdata_ext;
  logic        fault;
  logic        timeout_hit;

  lsu_align u_align (
    .funct3      (req_funct3),
    .addr_lo     (req_addr[1:0]),
    .wdata       (req_wdata),
    .be          (align_be),
    .wdata_rep   (align_wdata),
    .bad_f3      (bad_f3),
    .misalign    (misalign),
    .rsp_funct3  (f3_q),
    .rsp_addr_lo (alo_q),
    .rdata       (bus_rdata),
    .rdata_ext   (rdata_ext)
  );

  // Request faults that skip the bus entirely, and the watchdog threshold.
  always_comb begin
    fault       = bad_f3 | (MisalignExc & misalign);
    // Threshold is inclusive of the current cycle, so the last allowed cycle still sees gnt/rvalid.
    timeout_hit = (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));
  end

  // Main FSM with registered bus and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      txn_q       <= '0;
      f3_q        <= F3_B;
      alo_q       <= 2'b00;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            if (fault) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else begin
              txn_q       <= '{we: req_we, addr: {req_addr[31:2], 2'b00},
                               be: align_be, wdata: align_wdata};
              f3_q        <= req_funct3;
              alo_q       <= req_addr[1:0];
              cnt_q       <= '0;
              bus_req_q   <= 1'b1;
              state_q     <= REQ;
            end
          end
        end
        REQ: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (bus_gnt) begin
            bus_req_q <= 1'b0;
            if (txn_q.we) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b0;
              rsp_rdata_q <= '0;
            end else if (bus_rvalid) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b0;
              rsp_rdata_q <= rdata_ext;
            end else begin
              state_q <= WAIT;
            end
          end else if (timeout_hit) begin
            bus_req_q   <= 1'b0;
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (bus_rvalid) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= rdata_ext;
          end else if (timeout_hit) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
          end
        end
        RESP: begin
          // req_valid is deliberately ignored here so one instruction issues once.
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Output mapping; stall drops in RESP so the core advances on that edge.
  always_comb begin
    lsu_stall = ((state_q == IDLE) && req_valid) || (state_q == REQ) || (state_q == WAIT);
    rsp_valid = rsp_valid_q;
    rsp_rdata = rsp_rdata_q;
    rsp_err   = rsp_err_q;
    bus_req   = bus_req_q;
    bus_we    = txn_q.we;
    bus_addr  = txn_q.addr;
    bus_be    = txn_q.be;
    bus_wdata = txn_q.wdata;
  end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Self-checking bench for lsu_bus_ctrl: expected responses are queued as each
// access is driven and popped by a monitor when rsp_valid pulses.
module tb_lsu_bus_ctrl;
  import lsu_pkg::*;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        lsu_stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt = 1'b0;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = '0;

  always #5 clk = ~clk;

  lsu_bus_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .lsu_stall  (lsu_stall),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_gnt    (bus_gnt),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_rsp_t;

  exp_rsp_t exp_q[$];
  exp_rsp_t mon_e;

  // Scoreboard monitor: every response pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("rsp_rdata", rsp_rdata, mon_e.rdata);
        check_eq("rsp_err", {31'd0, rsp_err}, {31'd0, mon_e.err});
      end
    end
  end

  // One core access with a scripted slave; rv_wait < 0 means rvalid with gnt.
  task automatic run_access(input string tag, input logic we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input int gnt_wait, input int rv_wait, input logic [31:0] rd,
                            input logic [3:0] exp_be, input logic [31:0] exp_wd,
                            input logic [31:0] exp_rdata, input logic exp_err,
                            input logic exp_bus);
    int   cyc = 0;
    int   stall_n = 0;
    int   req_n = 0;
    int   wait_n = 0;
    int   lat = -1;
    int   busy;
    int   exp_lat;
    logic granted = 1'b0;
    logic rv_done = 1'b0;
    logic saw_bus = 1'b0;

    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    exp_q.push_back('{rdata: exp_rdata, err: exp_err});

    busy = gnt_wait + 1;
    if (!we && rv_wait >= 0) busy += rv_wait + 1;
    if (busy > int'(TO)) busy = int'(TO);
    exp_lat = exp_bus ? busy + 2 : 2;

    while (lat < 0 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (lsu_stall) stall_n++;
      if (rsp_valid) begin
        lat = cyc;
        check_eq({tag, "_breq_off"}, {31'd0, bus_req}, 32'd0);
      end else if (bus_req && !granted) begin
        saw_bus = 1'b1;
        if (req_n == gnt_wait) begin
          bus_gnt = 1'b1;
          granted = 1'b1;
          check_eq({tag, "_addr"}, bus_addr, {addr[31:2], 2'b00});
          check_eq({tag, "_be"}, {28'd0, bus_be}, {28'd0, exp_be});
          check_eq({tag, "_we"}, {31'd0, bus_we}, {31'd0, we});
          if (we) check_eq({tag, "_wdata"}, bus_wdata, exp_wd);
          if (rv_wait < 0) begin
            bus_rvalid = 1'b1;
            bus_rdata  = rd;
          end
        end
        req_n++;
      end else if (granted && !we && !rv_done && rv_wait >= 0) begin
        if (wait_n == rv_wait) begin
          bus_rvalid = 1'b1;
          bus_rdata  = rd;
          rv_done    = 1'b1;
        end
        wait_n++;
      end
      @(posedge clk);
      #1;
      bus_gnt    = 1'b0;
      bus_rvalid = 1'b0;
      if (lat >= 0) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_stall"}, 32'(stall_n), 32'(exp_lat - 1));
    check_eq({tag, "_bus_used"}, {31'd0, saw_bus}, {31'd0, exp_bus});
  endtask

  initial begin
    int guard;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("rst_bus_req", {31'd0, bus_req}, 32'd0);
    check_eq("rst_stall", {31'd0, lsu_stall}, 32'd0);
    check_eq("rst_be", {28'd0, bus_be}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    //          tag      we   f3     addr           wdata          gw  rw  rdata          be       wd            rdata          err bus
    run_access("sb",     1'b1, F3_B,  32'h0000_1003, 32'h0000_00A5, 1,  0,  32'h0,         4'b1000, 32'hA5A5A5A5, 32'h0,         0, 1);
    run_access("lb",     1'b0, F3_B,  32'h0000_2001, 32'h0,         0,  0,  32'h0000_80FF, 4'b0010, 32'h0,        32'hFFFFFF80,  0, 1);
    run_access("lbu",    1'b0, F3_BU, 32'h0000_2001, 32'h0,         0,  1,  32'h0000_80FF, 4'b0010, 32'h0,        32'h00000080,  0, 1);
    run_access("lhu",    1'b0, F3_HU, 32'h0000_2002, 32'h0,         2,  0,  32'hBEEF_1234, 4'b1100, 32'h0,        32'h0000BEEF,  0, 1);
    run_access("lh",     1'b0, F3_H,  32'h0000_2002, 32'h0,         0,  0,  32'h8001_5555, 4'b1100, 32'h0,        32'hFFFF8001,  0, 1);
    run_access("lb3",    1'b0, F3_B,  32'h0000_2003, 32'h0,         0,  0,  32'h7F00_0000, 4'b1000, 32'h0,        32'h0000007F,  0, 1);
    run_access("lw_same",1'b0, F3_W,  32'h0000_4004, 32'h0,         0,  -1, 32'hDEAD_BEEF, 4'b1111, 32'h0,        32'hDEADBEEF,  0, 1);
    run_access("sh",     1'b1, F3_H,  32'h0000_2002, 32'h1234_ABCD, 0,  0,  32'h0,         4'b1100, 32'hABCDABCD, 32'h0,         0, 1);
    run_access("sw",     1'b1, F3_W,  32'h0000_0040, 32'h1122_3344, 0,  0,  32'h0,         4'b1111, 32'h11223344, 32'h0,         0, 1);
    run_access("rsv",    1'b0, 3'b011,32'h0000_0010, 32'h0,         0,  0,  32'h0,         4'b0000, 32'h0,        32'h0,         1, 0);
    run_access("lw_to",  1'b0, F3_W,  32'h0000_6000, 32'h0,         100,-1, 32'h1111_2222, 4'b1111, 32'h0,        32'h0,         1, 1);
    run_access("lw_g16", 1'b0, F3_W,  32'h0000_6000, 32'h0,         int'(TO) - 1, -1, 32'hCAFE_F00D, 4'b1111, 32'h0, 32'hCAFEF00D, 0, 1);
`ifdef LSU_MISALIGN_EXC_EN
    run_access("lh_mis", 1'b0, F3_H,  32'h0000_3001, 32'h0,         0,  0,  32'h0000_F00D, 4'b0000, 32'h0,        32'h0,         1, 0);
`else
    run_access("lh_mis", 1'b0, F3_H,  32'h0000_3001, 32'h0,         0,  0,  32'h0000_F00D, 4'b0011, 32'h0,        32'hFFFFF00D,  0, 1);
`endif

    // Reset while a load waits for data; a late rvalid must be ignored.
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = F3_W;
    req_addr   = 32'h0000_5000;
    guard = 0;
    @(negedge clk);
    while (!bus_req && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    check_eq("rstw_reached_req", {31'd0, bus_req}, 32'd1);
    bus_gnt = 1'b1;
    @(posedge clk);
    #1;
    bus_gnt   = 1'b0;
    req_valid = 1'b0;
    check_eq("rstw_stall_wait", {31'd0, lsu_stall}, 32'd1);
    check_eq("rstw_addr_pre", bus_addr, 32'h0000_5000);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rstw_stall", {31'd0, lsu_stall}, 32'd0);
    check_eq("rstw_bus_req", {31'd0, bus_req}, 32'd0);
    check_eq("rstw_bus_we", {31'd0, bus_we}, 32'd0);
    check_eq("rstw_bus_addr", bus_addr, 32'd0);
    check_eq("rstw_bus_be", {28'd0, bus_be}, 32'd0);
    check_eq("rstw_bus_wdata", bus_wdata, 32'd0);
    check_eq("rstw_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("rstw_rsp_rdata", rsp_rdata, 32'd0);
    check_eq("rstw_rsp_err", {31'd0, rsp_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h1234_5678;
    @(posedge clk);
    #1;
    bus_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("late_rvalid_rsp", {31'd0, rsp_valid}, 32'd0);
      check_eq("late_rvalid_stall", {31'd0, lsu_stall}, 32'd0);
    end

    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
